// File: rtl/rx_polling_detect.sv
// Rx-side Detect/Polling substate engine: issues finishRx/gotoRx requests and the detected-lane write to the main LTSSM.
// Optional macro RX_POLL_TIMEOUT_EN enables the pollingActive/pollingConfiguration timeouts.
module rx_polling_detect #(
  parameter int DETECT_QUIET_CYCLES = 1200,
  parameter int POLL_ACTIVE_TIMEOUT = 2400,
  parameter int POLL_CONFIG_TIMEOUT = 4800,
  parameter int TS_COUNT            = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] substateRx,
  input  logic       elecIdleExit,
  input  logic       rxDetectValid,
  input  logic [4:0] rxDetectLanes,
  input  logic       tsValid,
  input  logic       tsType,
  input  logic       tsLinkPad,
  input  logic       tsLanePad,
  output logic       finishRx,
  output logic [3:0] gotoRx,
  output logic       writeNumberOfDetectedLanes,
  output logic [4:0] numberOfDetectedLanesOut
);

  typedef enum logic [3:0] {
    SUB_DETECT_QUIET  = 4'd0,
    SUB_DETECT_ACTIVE = 4'd1,
    SUB_POLL_ACTIVE   = 4'd2,
    SUB_POLL_CONFIG   = 4'd3,
    SUB_CFG_LW_START  = 4'd4
  } substate_e;

`ifdef RX_POLL_TIMEOUT_EN
  localparam bit POLL_TIMEOUT_EN = 1'b1;
`else
  localparam bit POLL_TIMEOUT_EN = 1'b0;
`endif

  localparam logic [15:0] DQ_LAST   = 16'(DETECT_QUIET_CYCLES - 1);
  localparam logic [15:0] PA_LAST   = 16'(POLL_ACTIVE_TIMEOUT - 1);
  localparam logic [15:0] PC_LAST   = 16'(POLL_CONFIG_TIMEOUT - 1);
  localparam logic [3:0]  TS_TARGET = 4'(TS_COUNT);

  substate_e   sub;
  logic [3:0]  last_sub_q, last_sub_d;
  logic [15:0] timer_q, timer_d;
  logic [3:0]  ts_cnt_q, ts_cnt_d;
  logic        done_q, done_d;
  logic        finish_rx_q, finish_rx_d;
  logic [3:0]  goto_rx_q, goto_rx_d;
  logic        write_lanes_q, write_lanes_d;
  logic [4:0]  lanes_q, lanes_d;

  logic [15:0] timer_inc;
  logic [3:0]  ts_cnt_next;
  logic        ts_qual;
  logic        timeout_hit;

  assign sub = substate_e'(substateRx);

  always_comb begin
    last_sub_d    = substateRx;
    timer_d       = timer_q;
    ts_cnt_d      = ts_cnt_q;
    done_d        = done_q;
    finish_rx_d   = 1'b0;
    goto_rx_d     = goto_rx_q;
    write_lanes_d = 1'b0;
    lanes_d       = lanes_q;

    timer_inc = (timer_q == '1) ? timer_q : timer_q + 16'd1;
    ts_qual   = tsLinkPad && tsLanePad && ((sub == SUB_POLL_ACTIVE) || tsType);

    ts_cnt_next = ts_cnt_q;
    if (tsValid) begin
      if (ts_qual) ts_cnt_next = (ts_cnt_q < TS_TARGET) ? ts_cnt_q + 4'd1 : ts_cnt_q;
      else         ts_cnt_next = '0;
    end

    timeout_hit = POLL_TIMEOUT_EN &&
                  (timer_q == ((sub == SUB_POLL_ACTIVE) ? PA_LAST : PC_LAST));

    if (substateRx != last_sub_q) begin
      timer_d  = '0;
      ts_cnt_d = '0;
      done_d   = 1'b0;
    end else if (!done_q) begin
      case (sub)
        SUB_DETECT_QUIET: begin
          if (elecIdleExit || (timer_q == DQ_LAST)) begin
            finish_rx_d = 1'b1;
            goto_rx_d   = SUB_DETECT_ACTIVE;
            done_d      = 1'b1;
          end else begin
            timer_d = timer_inc;
          end
        end
        SUB_DETECT_ACTIVE: begin
          if (rxDetectValid) begin
            finish_rx_d = 1'b1;
            done_d      = 1'b1;
            if (rxDetectLanes != '0) begin
              lanes_d       = rxDetectLanes;
              write_lanes_d = 1'b1;
              goto_rx_d     = SUB_POLL_ACTIVE;
            end else begin
              goto_rx_d = SUB_DETECT_QUIET;
            end
          end
        end
        SUB_POLL_ACTIVE, SUB_POLL_CONFIG: begin
          ts_cnt_d = ts_cnt_next;
          // Success is judged on the post-update count so it beats a same-cycle timeout.
          if (ts_cnt_next == TS_TARGET) begin
            finish_rx_d = 1'b1;
            done_d      = 1'b1;
            goto_rx_d   = (sub == SUB_POLL_ACTIVE) ? SUB_POLL_CONFIG : SUB_CFG_LW_START;
          end else if (timeout_hit) begin
            finish_rx_d = 1'b1;
            done_d      = 1'b1;
            goto_rx_d   = SUB_DETECT_QUIET;
          end else begin
            timer_d = timer_inc;
          end
        end
        default: begin
          timer_d  = '0;
          ts_cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_sub_q    <= '0;
      timer_q       <= '0;
      ts_cnt_q      <= '0;
      done_q        <= 1'b0;
      finish_rx_q   <= 1'b0;
      goto_rx_q     <= '0;
      write_lanes_q <= 1'b0;
      lanes_q       <= '0;
    end else begin
      last_sub_q    <= last_sub_d;
      timer_q       <= timer_d;
      ts_cnt_q      <= ts_cnt_d;
      done_q        <= done_d;
      finish_rx_q   <= finish_rx_d;
      goto_rx_q     <= goto_rx_d;
      write_lanes_q <= write_lanes_d;
      lanes_q       <= lanes_d;
    end
  end

  assign finishRx                   = finish_rx_q;
  assign gotoRx                     = goto_rx_q;
  assign writeNumberOfDetectedLanes = write_lanes_q;
  assign numberOfDetectedLanesOut   = lanes_q;

endmodule

// File: tb/tb_rx_polling_detect.sv
// Scoreboard bench for rx_polling_detect: scenarios push expected requests, a negedge monitor pops and compares.
module tb_rx_polling_detect;
  localparam int DQ  = 12;
  localparam int PAT = 24;
  localparam int PCT = 48;
  localparam int TSN = 8;
`ifdef RX_POLL_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] substateRx;
  logic       elecIdleExit, rxDetectValid, tsValid, tsType, tsLinkPad, tsLanePad;
  logic [4:0] rxDetectLanes;
  logic       finishRx, writeNumberOfDetectedLanes;
  logic [3:0] gotoRx;
  logic [4:0] numberOfDetectedLanesOut;

  rx_polling_detect #(
    .DETECT_QUIET_CYCLES(DQ),
    .POLL_ACTIVE_TIMEOUT(PAT),
    .POLL_CONFIG_TIMEOUT(PCT),
    .TS_COUNT(TSN)
  ) dut (
    .clk(clk), .reset(reset), .substateRx(substateRx), .elecIdleExit(elecIdleExit),
    .rxDetectValid(rxDetectValid), .rxDetectLanes(rxDetectLanes), .tsValid(tsValid),
    .tsType(tsType), .tsLinkPad(tsLinkPad), .tsLanePad(tsLanePad), .finishRx(finishRx),
    .gotoRx(gotoRx), .writeNumberOfDetectedLanes(writeNumberOfDetectedLanes),
    .numberOfDetectedLanesOut(numberOfDetectedLanesOut)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned cyc;
    logic [3:0]  goto_v;
    logic        wr;
    logic [4:0]  lanes;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int unsigned epoch = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  logic [4:0]  model_lanes = '0;
  logic        tv[0:99], tt[0:99], lp[0:99], np[0:99];

  function automatic void check(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endfunction

  exp_t        mon_e;
  logic [3:0]  hold_goto = '0;
  int unsigned hold_epoch = 0;
  bit          hold_set = 1'b0;

  always @(negedge clk) begin
    if (!reset) begin
      if (finishRx) begin
        if (sb.size() == 0) begin
          check("finishRx_unexpected", 32'(finishRx), 0);
        end else begin
          mon_e = sb.pop_front();
          check("finish_cycle", cyc, mon_e.cyc);
          check("gotoRx", 32'(gotoRx), 32'(mon_e.goto_v));
          check("write_strobe", 32'(writeNumberOfDetectedLanes), 32'(mon_e.wr));
          check("lanes_out", 32'(numberOfDetectedLanesOut), 32'(mon_e.lanes));
          hold_goto  = mon_e.goto_v;
          hold_epoch = epoch;
          hold_set   = 1'b1;
        end
      end else begin
        check("write_without_finish", 32'(writeNumberOfDetectedLanes), 0);
        if (hold_set && hold_epoch == epoch) check("gotoRx_hold", 32'(gotoRx), 32'(hold_goto));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear_inputs();
    elecIdleExit = 1'b0; rxDetectValid = 1'b0; rxDetectLanes = '0;
    tsValid = 1'b0; tsType = 1'b0; tsLinkPad = 1'b0; tsLanePad = 1'b0;
  endtask

  task automatic clear_arrays();
    for (int j = 0; j < 100; j++) begin
      tv[j] = 1'b0; tt[j] = 1'b0; lp[j] = 1'b0; np[j] = 1'b0;
    end
  endtask

  task automatic drive_ts(input int j);
    tsValid = tv[j]; tsType = tt[j]; tsLinkPad = lp[j]; tsLanePad = np[j];
  endtask

  task automatic enter(input logic [3:0] s);
    substateRx = s;
    epoch++;
  endtask

  task automatic go_idle();
    enter(($urandom_range(0, 1) != 0) ? 4'd4 : 4'd5);
    repeat (3) begin
      elecIdleExit  = 1'($urandom_range(0, 1));
      rxDetectValid = 1'($urandom_range(0, 1));
      rxDetectLanes = 5'($urandom_range(1, 31));
      tsValid = 1'b1; tsType = 1'($urandom_range(0, 1)); tsLinkPad = 1'b1; tsLanePad = 1'b1;
      tick();
    end
    clear_inputs();
  endtask

  task automatic finish_scenario();
    clear_inputs();
    tick();
    tick();
    check("pending_requests", 32'(sb.size()), 0);
    sb.delete();
  endtask

  task automatic sc_quiet(input int unsigned k);
    int unsigned e_cyc, r;
    go_idle();
    enter(4'd0);
    e_cyc = cyc;
    elecIdleExit = 1'b1;
    r = (k != 0 && k <= DQ) ? k : DQ;
    sb.push_back('{e_cyc + r + 1, 4'd1, 1'b0, model_lanes});
    for (int unsigned j = 1; j <= DQ + 6; j++) begin
      tick();
      elecIdleExit = (j == k) || (j == DQ + 3);
    end
    finish_scenario();
  endtask

  task automatic sc_active(input int unsigned d, input logic [4:0] lanes);
    int unsigned e_cyc;
    go_idle();
    enter(4'd1);
    e_cyc = cyc;
    rxDetectValid = 1'b1;
    rxDetectLanes = 5'($urandom_range(1, 31));
    if (lanes != 0) model_lanes = lanes;
    sb.push_back('{e_cyc + d + 1, (lanes != 0) ? 4'd2 : 4'd0, lanes != 0, model_lanes});
    for (int unsigned j = 1; j <= d + 4; j++) begin
      tick();
      rxDetectValid = (j == d) || (j == d + 2);
      rxDetectLanes = (j == d) ? lanes : 5'($urandom_range(1, 31));
    end
    finish_scenario();
  endtask

  task automatic sc_poll(input logic [3:0] s, input int n, input bit no_idle);
    int unsigned e_cyc, hit;
    int          cnt;
    logic [3:0]  g;
    bit          q;
    if (!no_idle) go_idle();
    enter(s);
    e_cyc = cyc;
    cnt = 0; hit = 0; g = '0;
    for (int j = 1; j <= n && hit == 0; j++) begin
      if (tv[j]) begin
        q   = lp[j] && np[j] && (s == 4'd2 || tt[j]);
        cnt = q ? cnt + 1 : 0;
      end
      if (cnt == TSN) begin
        hit = j; g = (s == 4'd2) ? 4'd3 : 4'd4;
      end else if (TO_EN && j == ((s == 4'd2) ? PAT : PCT)) begin
        hit = j; g = 4'd0;
      end
    end
    if (hit != 0) sb.push_back('{e_cyc + hit + 1, g, 1'b0, model_lanes});
    drive_ts(0);
    for (int j = 1; j <= n; j++) begin
      tick();
      drive_ts(j);
    end
    finish_scenario();
  endtask

  task automatic sc_poll_rand(input logic [3:0] s);
    int n;
    n = ((s == 4'd2) ? PAT : PCT) + 6;
    for (int j = 0; j <= n; j++) begin
      tv[j] = ($urandom_range(0, 3) != 0);
      lp[j] = ($urandom_range(0, 31) != 0);
      np[j] = ($urandom_range(0, 31) != 0);
      tt[j] = (s == 4'd2) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 7) != 0);
    end
    sc_poll(s, n, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    substateRx = 4'd5;
    clear_inputs();
    repeat (3) tick();
    check("reset_finishRx", 32'(finishRx), 0);
    check("reset_gotoRx", 32'(gotoRx), 0);
    check("reset_write", 32'(writeNumberOfDetectedLanes), 0);
    check("reset_lanes", 32'(numberOfDetectedLanesOut), 0);
    reset = 1'b0;
    tick();
    tick();

    sc_quiet(0);
    sc_quiet(5);
    sc_active(3, 5'd4);
    sc_active(2, 5'd0);

    // 5 PAD TS1, one non-PAD, then 8 PAD TS2
    clear_arrays();
    for (int j = 1; j <= 5; j++) begin tv[j] = 1'b1; lp[j] = 1'b1; np[j] = 1'b1; end
    tv[6] = 1'b1; lp[6] = 1'b0; np[6] = 1'b1;
    for (int j = 7; j <= 14; j++) begin tv[j] = 1'b1; tt[j] = 1'b1; lp[j] = 1'b1; np[j] = 1'b1; end
    sc_poll(4'd2, 20, 1'b0);

    // 7 TS2 then a TS1, nothing after
    clear_arrays();
    for (int j = 1; j <= 8; j++) begin tv[j] = 1'b1; tt[j] = (j != 8); lp[j] = 1'b1; np[j] = 1'b1; end
    sc_poll(4'd3, PCT + 4, 1'b0);

    // 8th TS2 lands on the timeout cycle
    clear_arrays();
    for (int j = PCT - 7; j <= PCT; j++) begin tv[j] = 1'b1; tt[j] = 1'b1; lp[j] = 1'b1; np[j] = 1'b1; end
    sc_poll(4'd3, PCT + 4, 1'b0);

    // reset in the middle of a pollingActive count of 6
    go_idle();
    enter(4'd2);
    clear_inputs();
    for (int j = 1; j <= 6; j++) begin
      tick();
      tsValid = 1'b1; tsType = 1'($urandom_range(0, 1)); tsLinkPad = 1'b1; tsLanePad = 1'b1;
    end
    tick();
    reset = 1'b1;
    epoch++;
    tick();
    check("midreset_finishRx", 32'(finishRx), 0);
    check("midreset_gotoRx", 32'(gotoRx), 0);
    check("midreset_write", 32'(writeNumberOfDetectedLanes), 0);
    check("midreset_lanes", 32'(numberOfDetectedLanesOut), 0);
    model_lanes = '0;
    reset = 1'b0;
    clear_inputs();
    clear_arrays();
    for (int j = 1; j <= 8; j++) begin tv[j] = 1'b1; tt[j] = 1'($urandom_range(0, 1)); lp[j] = 1'b1; np[j] = 1'b1; end
    sc_poll(4'd2, 14, 1'b1);

    repeat (24) begin
      case ($urandom_range(0, 3))
        0: sc_quiet($urandom_range(0, 16));
        1: sc_active($urandom_range(1, 5),
                     ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)));
        2: sc_poll_rand(4'd2);
        default: sc_poll_rand(4'd3);
      endcase
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
